mem_arbiter_ctrl: RTL and testbench

- Memory-side responder for the cache request protocol: the far end of dREN/dWEN/daddr/dstore to dwait/dload (dcache) and iREN/iaddr to iwait/iload (icache).
- Arbitrates the two caches onto the single-port RAM and forwards RAM completion back as wait/load.
- Sits between the cache pair and the RAM.
- Provides starvation protection for instruction fetch and per-requester transfer counters for debug and performance.

---
 rtl/mem_arbiter_ctrl_if.sv | 38 +++
 rtl/mem_arbiter_ctrl.sv | 137 +++++++++++++
 tb/tb_mem_arbiter_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_ctrl_if.sv
// mem_arbiter_ctrl_if
//   Bundles the cache request protocol and the RAM port seen by the memory arbiter.
//   slave  : the arbiter side (takes requests and RAM status, drives waits/loads and RAM controls)
//   master : the cache pair plus RAM side (drives requests and RAM status)
// Signals:
//   iREN/iaddr -> iwait/iload                     icache read channel
//   dREN/dWEN/daddr/dstore -> dwait/dload         dcache read/write channel
//   ramREN/ramWEN/ramaddr/ramstore <- ramload/ramstate  single-port RAM
interface mem_arbiter_ctrl_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl
//   Memory-side responder for the icache/dcache pair. Grants one cache at a time onto the
//   single-port RAM and returns RAM completion as a one-cycle wait=0 pulse with load data.
//   dcache wins ties unless icache has been passed over STARVE_LIMIT times in a row.
// Ports:
//   CLK     in   rising-edge clock
//   nRST    in   asynchronous active-low reset
//   bus     slave modport of mem_arbiter_ctrl_if (cache channels and RAM port)
//   err     out  sticky: RAM reported ERROR while a grant was active
//   dcount  out  completed dcache transfers (wraps)
//   icount  out  completed icache transfers (wraps)
module mem_arbiter_ctrl #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               CLK,
    input  logic               nRST,
    mem_arbiter_ctrl_if.slave  bus,
    output logic               err,
    output logic [CNT_W-1:0]   dcount,
    output logic [CNT_W-1:0]   icount
);

    localparam logic [1:0] RamAccess = 2'b10;
    localparam logic [1:0] RamError  = 2'b11;
    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StDgnt, StIgnt} state_e;

    state_e           state_q, state_d;
    logic [3:0]       starve_q, starve_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] dcount_q, dcount_d;
    logic [CNT_W-1:0] icount_q, icount_d;

    logic d_req;
    logic forced;

    assign d_req  = bus.dREN | bus.dWEN;
    // icache has waited through the allowed number of dcache grants
    assign forced = bus.iREN && (starve_q == StarveMax);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= StIdle;
            starve_q <= '0;
            err_q    <= 1'b0;
            dcount_q <= '0;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            err_q    <= err_d;
            dcount_q <= dcount_d;
            icount_q <= icount_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        err_d        = err_q;
        dcount_d     = dcount_q;
        icount_d     = icount_q;
        bus.iwait    = 1'b1;
        bus.iload    = '0;
        bus.dwait    = 1'b1;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;

        unique case (state_q)
            StIdle: begin
                if (!bus.iREN) begin
                    starve_d = '0;
                end
                if (d_req && !forced) begin
                    state_d = StDgnt;
                end else if (bus.iREN) begin
                    state_d = StIgnt;
                end
            end

            StDgnt: begin
                if (!d_req) begin
                    // Requester withdrew before ACCESS: release the RAM, count nothing
                    state_d = StIdle;
                end else begin
                    bus.ramaddr  = bus.daddr;
                    bus.ramstore = bus.dstore;
                    bus.ramWEN   = bus.dWEN;
                    bus.ramREN   = bus.dREN & ~bus.dWEN;
                    if (bus.ramstate == RamAccess) begin
                        bus.dwait = 1'b0;
                        bus.dload = bus.dWEN ? '0 : bus.ramload;
                        dcount_d  = dcount_q + CNT_W'(1);
                        state_d   = StIdle;
                        if (bus.iREN && (starve_q != StarveMax)) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end else if (bus.ramstate == RamError) begin
                        err_d = 1'b1;
                    end
                end
            end

            StIgnt: begin
                if (!bus.iREN) begin
                    state_d = StIdle;
                end else begin
                    bus.ramaddr = bus.iaddr;
                    bus.ramREN  = 1'b1;
                    if (bus.ramstate == RamAccess) begin
                        bus.iwait = 1'b0;
                        bus.iload = bus.ramload;
                        icount_d  = icount_q + CNT_W'(1);
                        starve_d  = '0;
                        state_d   = StIdle;
                    end else if (bus.ramstate == RamError) begin
                        err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign err    = err_q;
    assign dcount = dcount_q;
    assign icount = icount_q;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// tb_mem_arbiter_ctrl
//   Directed bench for mem_arbiter_ctrl: a per-cycle vector table for reads, writes, ERROR retry
//   and abort, plus hand-written sequences for starvation and asynchronous reset mid-grant.
module tb_mem_arbiter_ctrl;

    localparam int unsigned CNT_W = 16;
    localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACC = 2'b10, ERR = 2'b11;

    logic             CLK;
    logic             nRST;
    logic             err;
    logic [CNT_W-1:0] dcount;
    logic [CNT_W-1:0] icount;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter_ctrl_if bus ();

    mem_arbiter_ctrl #(
        .STARVE_LIMIT (4),
        .CNT_W        (CNT_W)
    ) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .bus    (bus.slave),
        .err    (err),
        .dcount (dcount),
        .icount (icount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        dren, dwen;
        logic [31:0] daddr, dstore;
        logic        iren;
        logic [31:0] iaddr;
        logic [1:0]  rs;
        logic [31:0] rl;
        logic        e_dwait;
        logic [31:0] e_dload;
        logic        e_iwait;
        logic [31:0] e_iload;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        int          e_dcnt, e_icnt;
        logic        e_err;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(
        input logic dren, input logic dwen, input logic [31:0] daddr, input logic [31:0] dstore,
        input logic iren, input logic [31:0] iaddr, input logic [1:0] rs, input logic [31:0] rl,
        input logic edw, input logic [31:0] edl, input logic eiw, input logic [31:0] eil,
        input logic eren, input logic ewen, input logic [31:0] eaddr, input logic [31:0] estore,
        input int edc, input int eic, input logic eerr);
        vec_t v;
        v.dren = dren; v.dwen = dwen; v.daddr = daddr; v.dstore = dstore;
        v.iren = iren; v.iaddr = iaddr; v.rs = rs; v.rl = rl;
        v.e_dwait = edw; v.e_dload = edl; v.e_iwait = eiw; v.e_iload = eil;
        v.e_ren = eren; v.e_wen = ewen; v.e_addr = eaddr; v.e_store = estore;
        v.e_dcnt = edc; v.e_icnt = eic; v.e_err = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic dren, input logic dwen, input logic [31:0] daddr,
                         input logic [31:0] dstore, input logic iren, input logic [31:0] iaddr,
                         input logic [1:0] rs, input logic [31:0] rl);
        bus.dREN = dren; bus.dWEN = dwen; bus.daddr = daddr; bus.dstore = dstore;
        bus.iREN = iren; bus.iaddr = iaddr; bus.ramstate = rs; bus.ramload = rl;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, FREE, 0);
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd_before_i, n_i, nd_after_i, n_done;
        logic drop_i;

        // Cycle-by-cycle table; counts/err reflect edges before the sampled cycle
        vecs[0]  = mk(1,0,'h100,0, 0,0, FREE,0, 1,0,1,0, 0,0,0,0, 0,0,0);
        vecs[1]  = mk(1,0,'h100,0, 0,0, BUSY,0, 1,0,1,0, 1,0,'h100,0, 0,0,0);
        vecs[2]  = mk(1,0,'h100,0, 0,0, BUSY,0, 1,0,1,0, 1,0,'h100,0, 0,0,0);
        vecs[3]  = mk(1,0,'h100,0, 0,0, ACC,'hDEADBEEF, 0,'hDEADBEEF,1,0, 1,0,'h100,0, 0,0,0);
        vecs[4]  = mk(0,0,0,0, 0,0, FREE,'hDEADBEEF, 1,0,1,0, 0,0,0,0, 1,0,0);
        vecs[5]  = mk(1,1,'h204,'h12345678, 0,0, FREE,0, 1,0,1,0, 0,0,0,0, 1,0,0);
        vecs[6]  = mk(1,1,'h204,'h12345678, 0,0, ACC,'hAAAA5555, 0,0,1,0,
                      0,1,'h204,'h12345678, 1,0,0);
        vecs[7]  = mk(0,0,0,0, 0,0, FREE,0, 1,0,1,0, 0,0,0,0, 2,0,0);
        vecs[8]  = mk(0,0,0,0, 1,'h40, FREE,0, 1,0,1,0, 0,0,0,0, 2,0,0);
        vecs[9]  = mk(0,0,0,0, 1,'h40, ERR,'h5555, 1,0,1,0, 1,0,'h40,0, 2,0,0);
        vecs[10] = mk(0,0,0,0, 1,'h40, ERR,'h5555, 1,0,1,0, 1,0,'h40,0, 2,0,1);
        vecs[11] = mk(0,0,0,0, 1,'h40, ERR,'h5555, 1,0,1,0, 1,0,'h40,0, 2,0,1);
        vecs[12] = mk(0,0,0,0, 1,'h40, ACC,'hCAFEF00D, 1,0,0,'hCAFEF00D, 1,0,'h40,0, 2,0,1);
        vecs[13] = mk(0,0,0,0, 0,0, FREE,0, 1,0,1,0, 0,0,0,0, 2,1,1);
        vecs[14] = mk(1,0,'h300,'h77, 1,'h44, FREE,0, 1,0,1,0, 0,0,0,0, 2,1,1);
        vecs[15] = mk(1,0,'h300,'h77, 1,'h44, BUSY,0, 1,0,1,0, 1,0,'h300,'h77, 2,1,1);
        vecs[16] = mk(0,0,'h300,'h77, 1,'h44, BUSY,0, 1,0,1,0, 0,0,0,0, 2,1,1);
        vecs[17] = mk(0,0,0,0, 1,'h44, BUSY,0, 1,0,1,0, 0,0,0,0, 2,1,1);
        vecs[18] = mk(0,0,0,0, 1,'h44, ACC,'h11112222, 1,0,0,'h11112222, 1,0,'h44,0, 2,1,1);
        vecs[19] = mk(0,0,0,0, 0,0, FREE,0, 1,0,1,0, 0,0,0,0, 2,2,1);

        nRST = 1'b1;
        drive(0, 0, 0, 0, 0, 0, FREE, 0);
        #1;
        nRST = 1'b0;
        #2;
        chk("reset_dwait", 32'(bus.dwait), 1);
        chk("reset_iwait", 32'(bus.iwait), 1);
        chk("reset_ramren", 32'(bus.ramREN), 0);
        chk("reset_ramaddr", bus.ramaddr, 0);
        chk("reset_dcount", 32'(dcount), 0);
        chk("reset_err", 32'(err), 0);
        do_reset();

        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            drive(vecs[i].dren, vecs[i].dwen, vecs[i].daddr, vecs[i].dstore,
                  vecs[i].iren, vecs[i].iaddr, vecs[i].rs, vecs[i].rl);
            #1;
            chk($sformatf("v%0d_dwait", i), 32'(bus.dwait), 32'(vecs[i].e_dwait));
            chk($sformatf("v%0d_dload", i), bus.dload, vecs[i].e_dload);
            chk($sformatf("v%0d_iwait", i), 32'(bus.iwait), 32'(vecs[i].e_iwait));
            chk($sformatf("v%0d_iload", i), bus.iload, vecs[i].e_iload);
            chk($sformatf("v%0d_ramREN", i), 32'(bus.ramREN), 32'(vecs[i].e_ren));
            chk($sformatf("v%0d_ramWEN", i), 32'(bus.ramWEN), 32'(vecs[i].e_wen));
            chk($sformatf("v%0d_ramaddr", i), bus.ramaddr, vecs[i].e_addr);
            chk($sformatf("v%0d_ramstore", i), bus.ramstore, vecs[i].e_store);
            chk($sformatf("v%0d_dcount", i), 32'(dcount), 32'(vecs[i].e_dcnt));
            chk($sformatf("v%0d_icount", i), 32'(icount), 32'(vecs[i].e_icnt));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].e_err));
        end

        // Starvation: iREN pending while dcache requests back-to-back, RAM always ACCESS.
        // Expect four dcache completions, one forced icache completion, then dcache again.
        do_reset();
        nd_before_i = 0; n_i = 0; nd_after_i = 0; n_done = 0; drop_i = 1'b0;
        for (int k = 0; k < 30 && n_done < 6; k++) begin
            @(negedge CLK);
            drive(1, 0, 'h500, 0, !drop_i, 'h40, ACC, 32'h1000 + 32'(k));
            #1;
            chk("starve_one_grant", 32'(bus.dwait & bus.iwait | (bus.dwait ^ bus.iwait)), 1);
            if (!bus.dwait) begin
                chk("starve_dload", bus.dload, 32'h1000 + 32'(k));
                if (n_i == 0) nd_before_i++;
                else nd_after_i++;
                n_done++;
            end
            if (!bus.iwait) begin
                chk("starve_iload", bus.iload, 32'h1000 + 32'(k));
                chk("starve_iaddr", bus.ramaddr, 'h40);
                n_i++;
                n_done++;
                drop_i = 1'b1;
            end
        end
        chk("starve_d_before_i", 32'(nd_before_i), 4);
        chk("starve_i_grants", 32'(n_i), 1);
        chk("starve_d_resumed", 32'(nd_after_i), 1);
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0, FREE, 0);
        #1;
        chk("starve_dcount", 32'(dcount), 5);
        chk("starve_icount", 32'(icount), 1);

        // Reset mid-grant: build nonzero dcount and err, then pull nRST during DGNT BUSY
        do_reset();
        @(negedge CLK); drive(1, 0, 'h600, 0, 0, 0, ACC, 'h1);   #1;
        @(negedge CLK);                                           #1;
        chk("rst_pre_dwait", 32'(bus.dwait), 0);
        @(negedge CLK); drive(1, 0, 'h600, 0, 0, 0, ERR, 'h1);   #1;
        @(negedge CLK);                                           #1;
        @(negedge CLK); drive(1, 0, 'h600, 0, 1, 'h80, BUSY, 0); #1;
        chk("rst_pre_ramren", 32'(bus.ramREN), 1);
        chk("rst_pre_err", 32'(err), 1);
        chk("rst_pre_dcount", 32'(dcount), 1);
        #1;
        nRST = 1'b0;
        #1;
        chk("rst_mid_dwait", 32'(bus.dwait), 1);
        chk("rst_mid_iwait", 32'(bus.iwait), 1);
        chk("rst_mid_ramren", 32'(bus.ramREN), 0);
        chk("rst_mid_ramwen", 32'(bus.ramWEN), 0);
        chk("rst_mid_ramaddr", bus.ramaddr, 0);
        chk("rst_mid_dcount", 32'(dcount), 0);
        chk("rst_mid_icount", 32'(icount), 0);
        chk("rst_mid_err", 32'(err), 0);
        @(negedge CLK);
        drive(1, 0, 'h604, 0, 0, 0, FREE, 0);
        nRST = 1'b1;
        @(negedge CLK); drive(1, 0, 'h604, 0, 0, 0, ACC, 'hBEEF0001); #1;
        chk("rst_post_dwait", 32'(bus.dwait), 0);
        chk("rst_post_dload", bus.dload, 'hBEEF0001);
        chk("rst_post_ramaddr", bus.ramaddr, 'h604);
        @(negedge CLK); drive(0, 0, 0, 0, 0, 0, FREE, 0); #1;
        chk("rst_post_dcount", 32'(dcount), 1);
        chk("rst_post_err", 32'(err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
